// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and helpers for the multi-port memory controller.
//   - state_t   : controller FSM states
//   - calc_len_w: width of a burst-length field (beats-1) for a given MAX_BURST
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // A single-beat MAX_BURST would give a zero-width field; keep at least 1 bit.
   function automatic int calc_len_w(input int max_burst);
      return (max_burst > 1) ? $clog2(max_burst) : 1;
   endfunction

endpackage

// File: rtl/mem_ctrl_mp_arb.sv
// rr_arbiter
//   Combinational rotate-priority arbiter. The search starts at ptr+1 and
//   wraps, so the port granted last has the lowest priority next time.
// Ports
//   req       in   NUM_PORTS  request vector
//   ptr       in   IDX_W      index of the most recently granted port
//   grant     out  NUM_PORTS  one-hot grant (all zero when req is zero)
//   grant_idx out  IDX_W      index of the granted port
module rr_arbiter #(
   parameter  int NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx
);

   always_comb begin
      logic found;
      int   idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(idx);
            grant     = NUM_PORTS'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp
//   Multi-port memory controller: NUM_PORTS requesters share one external
//   memory port under round-robin arbitration. Incrementing bursts, one
//   response pulse per beat, and a per-beat WAIT timeout that aborts the burst.
// Handshake: a requester holds req_valid (with write/addr/len) until it sees
//   its one-cycle req_ready pulse; the request is consumed by that pulse.
//   rsp_valid is a one-cycle, one-hot pulse per completed beat with no
//   back-pressure; rsp_rdata/rsp_last/rsp_err are 0 whenever rsp_valid is 0.
//   wr_data for a port must present the next beat after each of its rsp_valid.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/ready/write        per-port request handshake and direction
//   req_addr, req_len            packed per-port base address and beats-1
//   wr_data                      packed per-port current write beat
//   rsp_valid/rdata/last/err     per-beat response
//   busy                         1 whenever the FSM is not IDLE
//   ext_mem_*                    external memory port
//   state_dbg                    current FSM state, for observation only
module mem_ctrl_mp
   import mem_ctrl_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_WIDTH = 16,
   parameter  int NUM_PORTS  = 4,
   parameter  int MAX_BURST  = 8,
   parameter  int TIMEOUT    = 255,
   localparam int LEN_W      = calc_len_w(MAX_BURST),
   localparam int IDX_W      = $clog2(NUM_PORTS),
   localparam int TCNT_W     = $clog2(TIMEOUT)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]      req_len,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_PORTS-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic                            rsp_last,
   output logic                            rsp_err,
   output logic                            busy,
   output logic [ADDR_WIDTH-1:0]           ext_mem_addr,
   output logic                            ext_mem_read,
   output logic                            ext_mem_write,
   output logic [DATA_WIDTH-1:0]           ext_mem_wdata,
   input  logic [DATA_WIDTH-1:0]           ext_mem_rdata,
   input  logic                            ext_mem_ready,
   output logic [1:0]                      state_dbg
);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       port_q, port_d, ptr_q, ptr_d;
   logic                   wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [LEN_W-1:0]       len_q, len_d, beat_q, beat_d;
   logic [TCNT_W-1:0]      tcnt_q, tcnt_d;

   logic [NUM_PORTS-1:0]   req_ready_d, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_d, wdata_d;
   logic                   rsp_last_d, rsp_err_d, busy_d, rd_stb_d, wr_stb_d;
   logic [ADDR_WIDTH-1:0]  ext_addr_d;

   logic [NUM_PORTS-1:0]   grant;
   logic [IDX_W-1:0]       grant_idx;

   assign state_dbg = state_q;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      ptr_d       = ptr_q;
      wr_d        = wr_q;
      base_d      = base_q;
      len_d       = len_q;
      beat_d      = beat_q;
      tcnt_d      = tcnt_q;
      // Pulse outputs default low; strobe/address/data hold their last value.
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_last_d  = 1'b0;
      rsp_err_d   = 1'b0;
      ext_addr_d  = ext_mem_addr;
      rd_stb_d    = ext_mem_read;
      wr_stb_d    = ext_mem_write;
      wdata_d     = ext_mem_wdata;

      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               port_d      = grant_idx;
               ptr_d       = grant_idx;
               wr_d        = req_write[grant_idx];
               base_d      = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               len_d       = req_len[grant_idx*LEN_W +: LEN_W];
               beat_d      = '0;
               req_ready_d = grant;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
            ext_addr_d = base_q + ADDR_WIDTH'(beat_q);
            rd_stb_d   = !wr_q;
            wr_stb_d   = wr_q;
            wdata_d    = wr_data[port_q*DATA_WIDTH +: DATA_WIDTH];
            tcnt_d     = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            // Ready is tested first so a ready on the final allowed cycle
            // completes normally instead of timing out.
            if (ext_mem_ready) begin
               rd_stb_d    = 1'b0;
               wr_stb_d    = 1'b0;
               rsp_valid_d = NUM_PORTS'(1) << port_q;
               rsp_rdata_d = wr_q ? '0 : ext_mem_rdata;
               if (beat_q == len_q) begin
                  rsp_last_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  beat_d  = beat_q + LEN_W'(1);
                  state_d = ISSUE;
               end
            end else if (tcnt_q == TCNT_W'(TIMEOUT-1)) begin
               rd_stb_d    = 1'b0;
               wr_stb_d    = 1'b0;
               rsp_valid_d = NUM_PORTS'(1) << port_q;
               rsp_err_d   = 1'b1;
               rsp_last_d  = 1'b1;
               state_d     = IDLE;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         port_q        <= '0;
         ptr_q         <= IDX_W'(NUM_PORTS-1);
         wr_q          <= 1'b0;
         base_q        <= '0;
         len_q         <= '0;
         beat_q        <= '0;
         tcnt_q        <= '0;
         req_ready     <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_last      <= 1'b0;
         rsp_err       <= 1'b0;
         busy          <= 1'b0;
         ext_mem_addr  <= '0;
         ext_mem_read  <= 1'b0;
         ext_mem_write <= 1'b0;
         ext_mem_wdata <= '0;
      end else begin
         state_q       <= state_d;
         port_q        <= port_d;
         ptr_q         <= ptr_d;
         wr_q          <= wr_d;
         base_q        <= base_d;
         len_q         <= len_d;
         beat_q        <= beat_d;
         tcnt_q        <= tcnt_d;
         req_ready     <= req_ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_rdata     <= rsp_rdata_d;
         rsp_last      <= rsp_last_d;
         rsp_err       <= rsp_err_d;
         busy          <= busy_d;
         ext_mem_addr  <= ext_addr_d;
         ext_mem_read  <= rd_stb_d;
         ext_mem_write <= wr_stb_d;
         ext_mem_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// tb_mem_ctrl_mp
//   Directed and randomized bench for mem_ctrl_mp (4 ports, 32-bit data,
//   16-bit addresses, 8-beat bursts, TIMEOUT=16). Outputs are sampled on the
//   falling edge; a memory responder and per-port requesters are updated there.
module tb_mem_ctrl_mp;

   localparam int NP = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LW = 3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [NP*AW-1:0] req_addr;
   logic [NP*LW-1:0] req_len;
   logic [NP*DW-1:0] wr_data;
   logic [DW-1:0]    rsp_rdata, ext_mem_wdata, ext_mem_rdata;
   logic             rsp_last, rsp_err, busy, ext_mem_read, ext_mem_write, ext_mem_ready;
   logic [AW-1:0]    ext_mem_addr;
   logic [1:0]       state_dbg;

   mem_ctrl_mp #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .MAX_BURST(8), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .busy(busy),
      .ext_mem_addr(ext_mem_addr), .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
      .ext_mem_wdata(ext_mem_wdata), .ext_mem_rdata(ext_mem_rdata), .ext_mem_ready(ext_mem_ready),
      .state_dbg(state_dbg)
   );

   // ---------------- bench state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int viol     = 0;
   int m_ptr    = NP-1;       // reference round-robin pointer
   logic [31:0] salt;

   logic        ready_tied;   // memory answers every cycle, in or out of WAIT
   int          mem_lat;      // else: ready on the mem_lat-th strobe cycle (0 = never)
   int          wait_cnt, strobe_hi;
   logic        strobe_prev, rsp_prev, busy_after_rsp;

   logic        jw[NP];
   logic [15:0] jb[NP];
   int          jl[NP];
   logic [31:0] jwb[NP];
   int          beat_idx[NP];

   // observed logs
   logic [1:0]  g_log[$];
   logic [48:0] s_log[$];
   int          s_cyc[$];
   logic [37:0] r_log[$];
   int          r_cyc[$];
   // expected queues
   logic [1:0]  exp_gnt_q[$];
   logic [48:0] exp_str_q[$];
   logic [37:0] exp_rsp_q[$];

   // ---------------- helpers ----------------
   function automatic logic [31:0] data_of(input logic [15:0] a);
      if (a == 16'h0010) return 32'hDEADBEEF;
      return {a ^ 16'h5A5A, ~a} ^ salt;
   endfunction

   function automatic int oh_idx(input logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      g_log.delete(); s_log.delete(); s_cyc.delete(); r_log.delete(); r_cyc.delete();
      exp_gnt_q.delete(); exp_str_q.delete(); exp_rsp_q.delete();
      strobe_hi = 0;
   endtask

   // One clock: sample at the falling edge, then update requesters and memory.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (|req_ready) begin
         if (!$onehot(req_ready)) viol++;
         g_log.push_back(2'(oh_idx(req_ready)));
      end
      if (ext_mem_read || ext_mem_write) begin
         if (ext_mem_read && ext_mem_write) viol++;
         if (!strobe_prev) begin
            s_log.push_back({ext_mem_write, ext_mem_addr, ext_mem_wdata});
            s_cyc.push_back(cyc);
         end
         strobe_hi++;
         wait_cnt++;
         strobe_prev = 1'b1;
      end else begin
         wait_cnt    = 0;
         strobe_prev = 1'b0;
      end
      if (rsp_prev) busy_after_rsp = busy;
      rsp_prev = |rsp_valid;
      if (|rsp_valid) begin
         if (!$onehot(rsp_valid)) viol++;
         r_log.push_back({rsp_valid, rsp_rdata, rsp_last, rsp_err});
         r_cyc.push_back(cyc);
      end else if (rsp_rdata != '0 || rsp_last || rsp_err) begin
         viol++;
      end
      for (int p = 0; p < NP; p++) begin
         if (req_ready[p]) req_valid[p] = 1'b0;
         if (rsp_valid[p]) begin
            beat_idx[p]++;
            wr_data[p*DW +: DW] = jwb[p] + 32'(beat_idx[p]);
         end
      end
      ext_mem_ready = ready_tied ? 1'b1 : (strobe_prev && mem_lat > 0 && wait_cnt >= mem_lat);
      ext_mem_rdata = data_of(ext_mem_addr);
   endtask

   task automatic post_job(input int p, input logic w, input logic [15:0] base,
                           input int len, input logic [31:0] wb);
      jw[p] = w; jb[p] = base; jl[p] = len; jwb[p] = wb; beat_idx[p] = 0;
      req_valid[p]          = 1'b1;
      req_write[p]          = w;
      req_addr[p*AW +: AW]  = base;
      req_len[p*LW +: LW]   = 3'(len);
      wr_data[p*DW +: DW]   = wb;
   endtask

   // Reference: a burst of len+1 beats at consecutive (wrapping) addresses.
   task automatic model_job(input int p);
      for (int i = 0; i <= jl[p]; i++) begin
         logic [15:0] a;
         a = jb[p] + 16'(i);
         exp_str_q.push_back({jw[p], a, jwb[p] + 32'(i)});
         exp_rsp_q.push_back({4'(1 << p), jw[p] ? 32'h0 : data_of(a), (i == jl[p]), 1'b0});
      end
   endtask

   // Reference: serve every pending port, each time the first after the last winner.
   task automatic model_round(input logic [NP-1:0] mask);
      logic [NP-1:0] m;
      m = mask;
      while (m != '0) begin
         int pick;
         pick = -1;
         for (int k = 1; k <= NP; k++) begin
            int c;
            c = (m_ptr + k) % NP;
            if (pick < 0 && m[c]) pick = c;
         end
         exp_gnt_q.push_back(2'(pick));
         model_job(pick);
         m[pick] = 1'b0;
         m_ptr   = pick;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(req_valid == '0 && !busy) && n < budget);
      check("idle_reached", 64'(n < budget), 64'd1);
      tick();
      tick();
   endtask

   task automatic compare_round(input string tag);
      check($sformatf("%s_ngnt", tag), 64'(g_log.size()), 64'(exp_gnt_q.size()));
      for (int i = 0; i < exp_gnt_q.size() && i < g_log.size(); i++)
         check($sformatf("%s_gnt%0d", tag, i), 64'(g_log[i]), 64'(exp_gnt_q[i]));
      check($sformatf("%s_nstb", tag), 64'(s_log.size()), 64'(exp_str_q.size()));
      for (int i = 0; i < exp_str_q.size() && i < s_log.size(); i++)
         check($sformatf("%s_stb%0d", tag, i), 64'(s_log[i]), 64'(exp_str_q[i]));
      check($sformatf("%s_nrsp", tag), 64'(r_log.size()), 64'(exp_rsp_q.size()));
      for (int i = 0; i < exp_rsp_q.size() && i < r_log.size(); i++)
         check($sformatf("%s_rsp%0d", tag, i), 64'(r_log[i]), 64'(exp_rsp_q[i]));
      clear_logs();
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      tick();
      tick();
      reset_n = 1'b1;
      m_ptr   = NP-1;
      clear_logs();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      reset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
      wr_data = '0; ext_mem_rdata = '0; ext_mem_ready = 1'b0;
      ready_tied = 1'b1; mem_lat = 1; wait_cnt = 0; strobe_hi = 0;
      strobe_prev = 1'b0; rsp_prev = 1'b0; busy_after_rsp = 1'b0;
      for (int p = 0; p < NP; p++) begin
         jw[p] = 1'b0; jb[p] = '0; jl[p] = 0; jwb[p] = '0; beat_idx[p] = 0;
      end
      salt = $urandom;

      do_reset();
      tick();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_last, rsp_err}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ext", 64'({ext_mem_read, ext_mem_write, ext_mem_addr}), 64'd0);
      check("rst_wdata", 64'(ext_mem_wdata), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);

      // 1: single read, latency and one-cycle strobe
      begin
         int c0;
         clear_logs();
         post_job(0, 1'b0, 16'h0010, 0, 32'h0);
         c0 = cyc;
         model_round(4'b0001);
         wait_idle(50);
         check("t1_strobe_cyc", 64'(s_cyc.size() > 0 ? s_cyc[0] : -1), 64'(c0 + 2));
         check("t1_rsp_cyc", 64'(r_cyc.size() > 0 ? r_cyc[0] : -1), 64'(c0 + 3));
         check("t1_strobe_len", 64'(strobe_hi), 64'd1);
         check("t1_rdata", 64'(r_log.size() > 0 ? r_log[0][33:2] : 32'h0), 64'h0000_0000_DEAD_BEEF);
         compare_round("t1");
      end

      // 2: write burst wrapping the address space
      post_job(2, 1'b1, 16'hFFFE, 3, 32'hA0);
      model_round(4'b0100);
      wait_idle(80);
      check("t2_strobe_cycles", 64'(strobe_hi), 64'd4);
      check("t2_beat_period", 64'(r_cyc.size() == 4 ? r_cyc[3] - r_cyc[0] : -1), 64'd6);
      compare_round("t2");

      // 3: all ports from reset, then ports 1 and 3
      do_reset();
      for (int p = 0; p < NP; p++)
         post_job(p, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2), $urandom);
      model_round(4'b1111);
      wait_idle(200);
      for (int i = 0; i < NP; i++)
         check($sformatf("t3_order%0d", i), 64'(g_log.size() > i ? g_log[i] : 2'd0), 64'(i));
      compare_round("t3a");
      post_job(1, 1'b0, 16'h1234, 1, 32'h11);
      post_job(3, 1'b1, 16'h4321, 1, 32'h33);
      model_round(4'b1010);
      wait_idle(100);
      check("t3_second_first", 64'(g_log.size() > 0 ? g_log[0] : 2'd0), 64'd1);
      compare_round("t3b");

      // 4: timeout with ready held low
      ready_tied = 1'b0; mem_lat = 0;
      tick();
      post_job(1, 1'b0, 16'h0200, 3, 32'h0);
      m_ptr = 1;
      wait_idle(100);
      check("t4_nstb", 64'(s_log.size()), 64'd1);
      check("t4_strobe_cycles", 64'(strobe_hi), 64'd16);
      check("t4_nrsp", 64'(r_log.size()), 64'd1);
      check("t4_rsp_valid", 64'(r_log.size() > 0 ? r_log[0][37:34] : 4'h0), 64'b0010);
      check("t4_last_err", 64'(r_log.size() > 0 ? r_log[0][1:0] : 2'b00), 64'b11);
      check("t4_rsp_cyc", 64'(r_cyc.size() > 0 && s_cyc.size() > 0 ? r_cyc[0] - s_cyc[0] : -1), 64'd16);
      check("t4_busy_after", 64'(busy_after_rsp), 64'd0);
      clear_logs();

      // 5: reset in the middle of a 4-beat read
      ready_tied = 1'b1;
      do_reset();
      post_job(0, 1'b0, 16'h0300, 3, 32'h0);
      begin
         int n;
         n = 0;
         while (r_log.size() < 2 && n < 50) begin tick(); n++; end
         check("t5_two_beats", 64'(r_log.size()), 64'd2);
      end
      reset_n = 1'b0;
      tick();
      check("t5_outputs_zero",
            64'({req_ready, rsp_valid, rsp_last, rsp_err, busy, ext_mem_read, ext_mem_write}), 64'd0);
      check("t5_data_zero", 64'({rsp_rdata, ext_mem_addr} | 48'(ext_mem_wdata)), 64'd0);
      tick();
      reset_n = 1'b1;
      m_ptr   = NP-1;
      for (int i = 0; i < 4; i++) tick();
      check("t5_no_more_rsp", 64'(r_log.size()), 64'd2);
      clear_logs();
      post_job(3, 1'b0, 16'h0400, 0, 32'h0);
      model_round(4'b1000);
      wait_idle(50);
      compare_round("t5");

      // 6: ready arrives on the last allowed WAIT cycle
      ready_tied = 1'b0; mem_lat = 16;
      tick();
      post_job(1, 1'b0, 16'h0500, 0, 32'h0);
      model_round(4'b0010);
      wait_idle(100);
      check("t6_rsp_cyc", 64'(r_cyc.size() > 0 && s_cyc.size() > 0 ? r_cyc[0] - s_cyc[0] : -1), 64'd16);
      compare_round("t6");

      // random rounds
      for (int r = 0; r < 10; r++) begin
         logic [NP-1:0] mask;
         ready_tied = ($urandom_range(0, 2) == 0);
         mem_lat    = $urandom_range(1, 5);
         mask       = 4'($urandom_range(1, 15));
         tick();
         for (int p = 0; p < NP; p++)
            if (mask[p])
               post_job(p, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 7), $urandom);
         model_round(mask);
         wait_idle(600);
         compare_round($sformatf("rnd%0d", r));
      end

      check("protocol_viol", 64'(viol), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
